// File: rtl/esp8266_decode.sv
// esp8266_decode: receive-side parser for m("T","12.5")\r\n frames.
// Optional idle timeout is enabled by defining ESP_DECODE_TIMEOUT_EN.
module esp8266_decode #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  Rx_data,
  input  logic        Rx_valid,
  output logic [31:0] Data_out,
  output logic        Frame_valid,
  output logic        Frame_err,
  output logic        Busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_LP, S_Q1, S_TAG, S_Q2,
    S_COM, S_Q3, S_D1, S_D0, S_DOT,
    S_DF, S_Q4, S_RP, S_CR, S_LF
  } state_t;

  localparam logic [7:0] CH_M  = 8'h6d;
  localparam logic [7:0] CH_LP = 8'h28;
  localparam logic [7:0] CH_QT = 8'h22;
  localparam logic [7:0] CH_CM = 8'h2c;
  localparam logic [7:0] CH_DT = 8'h2e;
  localparam logic [7:0] CH_RP = 8'h29;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;

  state_t      state_q, state_d;
  logic [7:0]  tag_q, tag_d;
  logic [7:0]  d1_q, d1_d;
  logic [7:0]  d0_q, d0_d;
  logic [7:0]  df_q, df_d;
  logic [31:0] data_q, data_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;
  logic        busy_q, busy_d;

`ifdef ESP_DECODE_TIMEOUT_EN
  localparam logic [23:0] TO_LAST =
    24'(TIMEOUT_CYC - 1);
  logic [23:0] idle_q, idle_d;
`endif

  logic       is_digit;
  logic [7:0] dig_val;
  logic       ok;
  state_t     nxt;

  always_comb begin
    is_digit = (Rx_data >= 8'h30) &&
               (Rx_data <= 8'h39);
    dig_val  = {4'h0, Rx_data[3:0]};
    ok       = 1'b0;
    nxt      = state_q;
    unique case (state_q)
      S_IDLE: begin
        ok = (Rx_data == CH_M);  nxt = S_LP;
      end
      S_LP: begin
        ok = (Rx_data == CH_LP); nxt = S_Q1;
      end
      S_Q1: begin
        ok = (Rx_data == CH_QT); nxt = S_TAG;
      end
      S_TAG: begin
        ok = (Rx_data != CH_QT); nxt = S_Q2;
      end
      S_Q2: begin
        ok = (Rx_data == CH_QT); nxt = S_COM;
      end
      S_COM: begin
        ok = (Rx_data == CH_CM); nxt = S_Q3;
      end
      S_Q3: begin
        ok = (Rx_data == CH_QT); nxt = S_D1;
      end
      S_D1: begin
        ok = is_digit; nxt = S_D0;
      end
      S_D0: begin
        ok = is_digit; nxt = S_DOT;
      end
      S_DOT: begin
        ok = (Rx_data == CH_DT); nxt = S_DF;
      end
      S_DF: begin
        ok = is_digit; nxt = S_Q4;
      end
      S_Q4: begin
        ok = (Rx_data == CH_QT); nxt = S_RP;
      end
      S_RP: begin
        ok = (Rx_data == CH_RP); nxt = S_CR;
      end
      S_CR: begin
        ok = (Rx_data == CH_CR); nxt = S_LF;
      end
      S_LF: begin
        ok = (Rx_data == CH_LF); nxt = S_IDLE;
      end
      default: begin
        ok = 1'b0; nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    df_d    = df_q;
    data_d  = data_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    if (Rx_valid) begin
      if (ok) begin
        state_d = nxt;
        if (state_q == S_TAG) tag_d = Rx_data;
        if (state_q == S_D1)  d1_d  = dig_val;
        if (state_q == S_D0)  d0_d  = dig_val;
        if (state_q == S_DF)  df_d  = dig_val;
        if (state_q == S_LF) begin
          fv_d   = 1'b1;
          data_d = {tag_q, d1_q, d0_q, df_q};
        end
      end else if (state_q != S_IDLE) begin
        fe_d    = 1'b1;
        state_d = (Rx_data == CH_M) ?
                  S_LP : S_IDLE;
      end
    end
`ifdef ESP_DECODE_TIMEOUT_EN
    idle_d = idle_q;
    if (Rx_valid || !busy_q) begin
      idle_d = '0;
    end else if (idle_q == TO_LAST) begin
      idle_d  = '0;
      state_d = S_IDLE;
      fe_d    = 1'b1;
    end else begin
      idle_d = idle_q + 24'd1;
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      d1_q    <= '0;
      d0_q    <= '0;
      df_q    <= '0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ESP_DECODE_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      df_q    <= df_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
`ifdef ESP_DECODE_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign Data_out    = data_q;
  assign Frame_valid = fv_q;
  assign Frame_err   = fe_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_esp8266_decode.sv
// tb_esp8266_decode: scoreboard bench for the ESP8266 frame parser.
// Template-based reference model; random and directed byte streams.
`timescale 1ns/1ps
module tb_esp8266_decode;

  localparam int TO = 100;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic [7:0]  Rx_data = 8'h00;
  logic        Rx_valid = 1'b0;
  logic [31:0] Data_out;
  logic        Frame_valid;
  logic        Frame_err;
  logic        Busy;

  always #5 Clk = ~Clk;

  esp8266_decode #(.TIMEOUT_CYC(TO)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Rx_data(Rx_data),
    .Rx_valid(Rx_valid),
    .Data_out(Data_out),
    .Frame_valid(Frame_valid),
    .Frame_err(Frame_err),
    .Busy(Busy)
  );

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  tpl[$];
  logic [7:0]  cap[15];
  int          mpos = 0;
  int          midle = 0;
  logic [31:0] held = 32'h0;
  logic [7:0]  fq[$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] t;
    bit         ok;
    t = tpl[mpos];
    if (t == "?")      ok = (b != 8'h22);
    else if (t == "#") ok = (b >= "0" && b <= "9");
    else               ok = (b == t);
    if (ok) begin
      cap[mpos] = b;
      mpos++;
      if (mpos == tpl.size()) begin
        sbq.push_back('{1'b0,
          {cap[3], cap[7] - 8'h30,
           cap[8] - 8'h30, cap[10] - 8'h30}});
        mpos = 0;
      end
    end else if (mpos != 0) begin
      sbq.push_back('{1'b1, 32'h0});
      mpos = (b == "m") ? 1 : 0;
    end
  endtask

  always @(posedge Clk) begin
    if (!Rst_n) begin
      mpos  = 0;
      midle = 0;
    end else if (Rx_valid) begin
      midle = 0;
      model_byte(Rx_data);
    end else if (mpos != 0) begin
      midle++;
`ifdef ESP_DECODE_TIMEOUT_EN
      if (midle == TO) begin
        sbq.push_back('{1'b1, 32'h0});
        mpos  = 0;
        midle = 0;
      end
`endif
    end else begin
      midle = 0;
    end
  end

  exp_t e;
  always @(negedge Clk) begin
    if (!Rst_n) begin
      held = 32'h0;
      check("reset_outputs",
            {Data_out, Frame_valid, Frame_err, Busy},
            64'h0);
    end else begin
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check(e.err ? "err_pulse" : "valid_pulse",
              {Frame_valid, Frame_err},
              e.err ? 2'b01 : 2'b10);
        if (!e.err) held = e.data;
      end else begin
        check("no_pulse",
              {Frame_valid, Frame_err}, 2'b00);
      end
      check("data_out", Data_out, held);
      check("busy", Busy, (mpos != 0));
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    Rx_data  = b;
    Rx_valid = 1'b1;
    @(negedge Clk);
    Rx_valid = 1'b0;
    Rx_data  = 8'($urandom);
    repeat (gap) @(negedge Clk);
  endtask

  task automatic send_str(input string s,
                          input int gap);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], gap);
  endtask

  task automatic send_frame(input string body,
                            input int gap);
    send_str(body, gap);
    send_byte(8'h0d, gap);
    send_byte(8'h0a, gap);
  endtask

  task automatic mk_frame(input logic [7:0] tag,
                          input int a,
                          input int b,
                          input int c);
    fq = {8'h6d, 8'h28, 8'h22, tag, 8'h22,
          8'h2c, 8'h22,
          8'(48 + a), 8'(48 + b), 8'h2e,
          8'(48 + c),
          8'h22, 8'h29, 8'h0d, 8'h0a};
  endtask

  initial begin
    string s;
    s = "m(\"?\",\"##.#\")";
    for (int i = 0; i < s.len(); i++)
      tpl.push_back(s[i]);
    tpl.push_back(8'h0d);
    tpl.push_back(8'h0a);

    #1 Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    send_frame("m(\"T\",\"12.5\")", 3);
    repeat (2) @(negedge Clk);
    check("tp1_data", Data_out, 32'h54010205);

    send_frame("m(\"H\",\"9x.1\")", 1);
    repeat (2) @(negedge Clk);
    check("tp2_data_kept", Data_out, 32'h54010205);

    send_str("ab", 1);
    send_frame("m(\"A\",\"00.0\")", 0);
    repeat (2) @(negedge Clk);
    check("tp3_data", Data_out, 32'h41000000);

    send_frame("m(\"T\",\"1m(\"B\",\"34.7\")", 2);
    repeat (2) @(negedge Clk);
    check("tp4_data", Data_out, 32'h42030407);

    send_str("m(\"T", 1);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_mid_busy", Busy, 1'b0);
    Rst_n = 1'b1;
    @(negedge Clk);
    send_frame("m(\"Z\",\"98.6\")", 0);
    send_frame("m(\"Q\",\"45.3\")", 0);
    repeat (2) @(negedge Clk);
    check("b2b_data", Data_out, 32'h51040503);

`ifdef ESP_DECODE_TIMEOUT_EN
    send_str("m(", 0);
    repeat (TO + 10) @(negedge Clk);
    check("timeout_busy", Busy, 1'b0);
`else
    send_str("m(", 0);
    repeat (110) @(negedge Clk);
    check("no_timeout_busy", Busy, 1'b1);
    send_byte("z", 2);
`endif

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        int k;
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++)
          send_byte(8'($urandom),
                    $urandom_range(0, 3));
      end else begin
        mk_frame(8'($urandom),
                 $urandom_range(0, 9),
                 $urandom_range(0, 9),
                 $urandom_range(0, 9));
        if (kind == 2)
          fq[$urandom_range(1, 14)] = 8'($urandom);
        foreach (fq[j])
          send_byte(fq[j], $urandom_range(0, 3));
      end
    end

    repeat (5) @(negedge Clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/esp8266_decode.md
Name: esp8266_decode

Overview:
- Receive-side parser for the ESP8266 text link: consumes a byte stream from the UART receiver.
- Recognises frames of the form m("T","12.5")\r\n, i.e. the same frame format our transmit path emits.
- Extracts the tag character and three decimal digits into a 32-bit word laid out exactly like the transmit-side payload, then pulses a valid strobe.
- Sits between the UART RX byte assembler and the command/display logic.

Parameters:
- TIMEOUT_CYC, 2000000, inter-byte idle limit in Clk cycles (40 ms at 50 MHz); used only when ESP_DECODE_TIMEOUT_EN is defined.

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  reset; asynchronous, active-low.
- Rx_data  input  8  received byte; qualified by Rx_valid.
- Rx_valid  input  1  single-cycle strobe; one byte per high cycle; no back-pressure.
- Data_out  output  32  [31:24] tag byte raw; [23:16] tens digit; [15:8] units digit; [7:0] tenths digit (digits binary 0..9).
- Frame_valid  output  1  one-cycle pulse; a complete valid frame has been decoded.
- Frame_err  output  1  one-cycle pulse; frame aborted (bad byte or timeout).
- Busy  output  1  high while the parser is past IDLE (mid-frame).

Behaviour:
- Reset: Data_out=0, Frame_valid=0, Frame_err=0, Busy=0, state=IDLE, digit shadow registers=0.
- State advances only on cycles with Rx_valid=1; bytes are ignored otherwise.
- States and expected bytes, in order: IDLE 'm'; S_LP '('; S_Q1 '"'; S_TAG any byte except '"' (latched); S_Q2 '"'; S_COM ','; S_Q3 '"'; S_D1 digit; S_D0 digit; S_DOT '.'; S_DF digit; S_Q4 '"'; S_RP ')'; S_CR '\r'; S_LF '\n'.
- A digit is 0x30..0x39; the stored value is byte-0x30, 4 bits zero-extended to 8.
- IDLE: a non-'m' byte is silently discarded; no Frame_err.
- Mismatch in any state other than IDLE: Frame_err pulses the next cycle. Resync rule: if the offending byte is 'm', go to S_LP; otherwise go to IDLE.
- Completion: on accepting '\n' in S_LF, on the next cycle Data_out updates atomically from the shadow registers and Frame_valid=1 for exactly one cycle; state returns to IDLE.
- Latency: Frame_valid is one cycle after the '\n' Rx_valid cycle.
- Data_out holds its value until the next valid frame; aborted frames never alter Data_out.
- Shadow tag/digit registers are written as bytes are accepted and are invisible to the outside.
- Back-to-back frames: an 'm' arriving the cycle after '\n' is accepted normally.
- Busy = (state != IDLE), registered.
- Frame_valid and Frame_err are never high in the same cycle.

Optional Feature:
- Macro: ESP_DECODE_TIMEOUT_EN.
- Defined: a 24-bit idle counter clears on every Rx_valid and increments while Busy=1. When it reaches TIMEOUT_CYC-1 with no byte, the parser returns to IDLE and Frame_err pulses once. A byte arriving on the same cycle as the timeout wins: it is processed and the counter clears.
- Undefined: no counter; the parser waits indefinitely mid-frame.

Test Plan:
- Reset, then bytes m("T","12.5")\r\n, one every 4 cycles -> one Frame_valid pulse the cycle after '\n'; Data_out=0x54010205; Frame_err never asserted.
- Valid frame then m("H","9x.1")\r\n -> Frame_err pulses after 'x'; Data_out keeps its old value; no Frame_valid.
- Garbage "ab" then m("A","00.0")\r\n -> no Frame_err for "ab"; Data_out=0x41000000 with Frame_valid.
- m("T","1m("B","34.7")\r\n -> Frame_err at the second 'm', resync to S_LP; Frame_valid with Data_out=0x42030407.
- Assert Rst_n low mid-frame after "m(\"T" -> all outputs 0, Busy=0; the next full frame decodes normally.
- With ESP_DECODE_TIMEOUT_EN and TIMEOUT_CYC=100: send "m(" then stall 100 cycles -> a single Frame_err pulse and Busy drops; without the macro, Busy stays 1.
